// File: rtl/pattern_hit_counter.sv
// pattern_hit_counter: counts rising edges of the pattern detector output as a
// 3-digit BCD event counter (000-999) with a sticky overflow flag. The count is
// shown on three active-low seven-segment digits with optional leading-zero
// blanking. The display registers refresh from the count register every clock,
// which gives one cycle of display latency.
module pattern_hit_counter #(
  parameter bit SATURATE      = 1'b0,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        detect,
  input  logic        clear,
  output logic [11:0] count_bcd,
  output logic        overflow,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2
);

  localparam logic [6:0] SEG_BLANK = 7'h7f;
  localparam logic [6:0] SEG_ZERO  = 7'h40;
  // A count of 000 shows "0" on the ones digit; upper digits depend on blanking.
  localparam logic [6:0] HEX_UPPER_RST = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;

  logic [3:0] ones_q, tens_q, hund_q;
  logic [3:0] ones_d, tens_d, hund_d;
  logic       overflow_q, overflow_d;
  logic       detect_prev_q, detect_prev_d;
  logic [6:0] hex0_q, hex1_q, hex2_q;
  logic [6:0] hex0_d, hex1_d, hex2_d;
  logic       hit;
  logic       at_max;

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h18;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  assign hit    = enable & detect & ~detect_prev_q;
  assign at_max = (hund_q == 4'd9) && (tens_q == 4'd9) && (ones_q == 4'd9);

  // Next count, overflow and edge-detect history; clear beats a coincident hit.
  always_comb begin
    ones_d        = ones_q;
    tens_d        = tens_q;
    hund_d        = hund_q;
    overflow_d    = overflow_q;
    detect_prev_d = enable ? detect : detect_prev_q;

    if (clear) begin
      ones_d     = 4'd0;
      tens_d     = 4'd0;
      hund_d     = 4'd0;
      overflow_d = 1'b0;
    end else if (hit) begin
      if (at_max) begin
        overflow_d = 1'b1;
        if (!SATURATE) begin
          ones_d = 4'd0;
          tens_d = 4'd0;
          hund_d = 4'd0;
        end
      end else if (ones_q != 4'd9) begin
        ones_d = ones_q + 4'd1;
      end else begin
        ones_d = 4'd0;
        if (tens_q != 4'd9) begin
          tens_d = tens_q + 4'd1;
        end else begin
          tens_d = 4'd0;
          hund_d = hund_q + 4'd1;
        end
      end
    end
  end

  // Display decode from the registered count, with leading-zero blanking.
  always_comb begin
    hex0_d = seg7(ones_q);
    hex1_d = seg7(tens_q);
    hex2_d = seg7(hund_q);
    if (BLANK_LEADING) begin
      if (hund_q == 4'd0) begin
        hex2_d = SEG_BLANK;
        if (tens_q == 4'd0) begin
          hex1_d = SEG_BLANK;
        end
      end
    end
  end

  // Count, flag, history and display registers; reset clears everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ones_q        <= 4'd0;
      tens_q        <= 4'd0;
      hund_q        <= 4'd0;
      overflow_q    <= 1'b0;
      detect_prev_q <= 1'b0;
      hex0_q        <= SEG_ZERO;
      hex1_q        <= HEX_UPPER_RST;
      hex2_q        <= HEX_UPPER_RST;
    end else begin
      ones_q        <= ones_d;
      tens_q        <= tens_d;
      hund_q        <= hund_d;
      overflow_q    <= overflow_d;
      detect_prev_q <= detect_prev_d;
      hex0_q        <= hex0_d;
      hex1_q        <= hex1_d;
      hex2_q        <= hex2_d;
    end
  end

  assign count_bcd = {hund_q, tens_q, ones_q};
  assign overflow  = overflow_q;
  assign hex0      = hex0_q;
  assign hex1      = hex1_q;
  assign hex2      = hex2_q;

endmodule

// File: tb/tb_pattern_hit_counter.sv
// Bench for pattern_hit_counter: two instances (wrap+blanking, saturate+no
// blanking) share one stimulus stream and are compared against an integer
// reference model, a hand-derived vector table and hand-written corner cases.
module tb_pattern_hit_counter;

  logic clock;
  logic reset;
  logic enable;
  logic detect;
  logic clear;

  logic [11:0] cb  [2];
  logic        ov  [2];
  logic [6:0]  hx0 [2];
  logic [6:0]  hx1 [2];
  logic [6:0]  hx2 [2];

  int checks = 0;
  int errors = 0;

  pattern_hit_counter #(.SATURATE(1'b0), .BLANK_LEADING(1'b1)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .detect(detect), .clear(clear),
    .count_bcd(cb[0]), .overflow(ov[0]), .hex0(hx0[0]), .hex1(hx1[0]), .hex2(hx2[0])
  );

  pattern_hit_counter #(.SATURATE(1'b1), .BLANK_LEADING(1'b0)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .detect(detect), .clear(clear),
    .count_bcd(cb[1]), .overflow(ov[1]), .hex0(hx0[1]), .hex1(hx1[1]), .hex2(hx2[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer count per instance.
  bit         sat_m [2] = '{1'b0, 1'b1};
  bit         blk_m [2] = '{1'b1, 1'b0};
  int         cnt_m [2];
  bit         ovf_m [2];
  bit         prev_m;
  logic [6:0] h0_m [2];
  logic [6:0] h1_m [2];
  logic [6:0] h2_m [2];
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

  function automatic logic [11:0] to_bcd(input int c);
    return 12'((c / 100) * 256 + ((c / 10) % 10) * 16 + (c % 10));
  endfunction

  task automatic model_display(input int i);
    int h, t, o;
    h = cnt_m[i] / 100;
    t = (cnt_m[i] / 10) % 10;
    o = cnt_m[i] % 10;
    h0_m[i] = seg_tab[o];
    h1_m[i] = (blk_m[i] && h == 0 && t == 0) ? 7'h7f : seg_tab[t];
    h2_m[i] = (blk_m[i] && h == 0) ? 7'h7f : seg_tab[h];
  endtask

  task automatic model_reset();
    prev_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cnt_m[i] = 0;
      ovf_m[i] = 1'b0;
      model_display(i);
    end
  endtask

  task automatic model_edge(input bit en, input bit det, input bit clr);
    bit h;
    h = en && det && !prev_m;
    for (int i = 0; i < 2; i++) begin
      model_display(i);  // display captures the count before this edge
      if (clr) begin
        cnt_m[i] = 0;
        ovf_m[i] = 1'b0;
      end else if (h) begin
        if (cnt_m[i] == 999) begin
          ovf_m[i] = 1'b1;
          cnt_m[i] = sat_m[i] ? 999 : 0;
        end else begin
          cnt_m[i] = cnt_m[i] + 1;
        end
      end
    end
    if (en) prev_m = det;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.count[%0d]", tag, i), int'(cb[i]), int'(to_bcd(cnt_m[i])));
      chk($sformatf("%s.ovf[%0d]", tag, i), int'(ov[i]), int'(ovf_m[i]));
      chk($sformatf("%s.hex0[%0d]", tag, i), int'(hx0[i]), int'(h0_m[i]));
      chk($sformatf("%s.hex1[%0d]", tag, i), int'(hx1[i]), int'(h1_m[i]));
      chk($sformatf("%s.hex2[%0d]", tag, i), int'(hx2[i]), int'(h2_m[i]));
    end
  endtask

  task automatic do_step(input bit en, input bit det, input bit clr, input string tag);
    enable = en;
    detect = det;
    clear  = clr;
    @(posedge clock);
    model_edge(en, det, clr);
    #1;
    check_all(tag);
  endtask

  task automatic hits(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      do_step(1'b1, 1'b1, 1'b0, tag);
      do_step(1'b1, 1'b0, 1'b0, tag);
    end
  endtask

  typedef struct {
    bit          en;
    bit          det;
    bit          clr;
    logic [11:0] exp_cnt;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 12'h000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 12'h001};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 12'h001};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 12'h001};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 12'h001};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 12'h001};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 12'h001};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 12'h001};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 12'h001};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 12'h001};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 12'h001};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 12'h002};

    reset  = 1'b1;
    enable = 1'b0;
    detect = 1'b0;
    clear  = 1'b0;
    model_reset();
    #2;
    // Reset with no clock edge yet.
    chk("rst.count0", int'(cb[0]), 'h000);
    chk("rst.ovf0", int'(ov[0]), 0);
    chk("rst.hex0", int'(hx0[0]), 'h40);
    chk("rst.hex1", int'(hx1[0]), 'h7f);
    chk("rst.hex2", int'(hx2[0]), 'h7f);
    chk("rst.hex2_noblank", int'(hx2[1]), 'h40);
    check_all("rst");
    #1 reset = 1'b0;

    // Single hit, hold, enable gating.
    for (int v = 0; v < 12; v++) begin
      do_step(tbl[v].en, tbl[v].det, tbl[v].clr, $sformatf("tbl%0d", v));
      chk($sformatf("tbl%0d.vec0", v), int'(cb[0]), int'(tbl[v].exp_cnt));
      chk($sformatf("tbl%0d.vec1", v), int'(cb[1]), int'(tbl[v].exp_cnt));
      if (v == 2) chk("single.hex0_latency", int'(hx0[0]), 'h79);
    end

    // Carry into tens and hundreds with blanking.
    do_step(1'b1, 1'b0, 1'b1, "clr");
    hits(10, "carry10");
    chk("c10.count", int'(cb[0]), 'h010);
    chk("c10.hex0", int'(hx0[0]), 'h40);
    chk("c10.hex1", int'(hx1[0]), 'h79);
    chk("c10.hex2", int'(hx2[0]), 'h7f);
    hits(90, "carry100");
    chk("c100.count", int'(cb[0]), 'h100);
    chk("c100.hex0", int'(hx0[0]), 'h40);
    chk("c100.hex1", int'(hx1[0]), 'h40);
    chk("c100.hex2", int'(hx2[0]), 'h79);

    // Wrap / saturate at 999.
    do_step(1'b1, 1'b0, 1'b1, "clr");
    hits(999, "pre999");
    chk("p999.count0", int'(cb[0]), 'h999);
    chk("p999.ovf0", int'(ov[0]), 0);
    hits(1, "wrap");
    chk("wrap.count0", int'(cb[0]), 'h000);
    chk("wrap.ovf0", int'(ov[0]), 1);
    chk("sat.count1", int'(cb[1]), 'h999);
    chk("sat.ovf1", int'(ov[1]), 1);
    hits(5, "post");
    chk("post.count0", int'(cb[0]), 'h005);
    chk("post.ovf0", int'(ov[0]), 1);
    chk("post.count1", int'(cb[1]), 'h999);

    // Clear collides with a hit; held detect must not recount afterwards.
    do_step(1'b1, 1'b1, 1'b1, "clrhit");
    chk("clrhit.count0", int'(cb[0]), 'h000);
    chk("clrhit.ovf0", int'(ov[0]), 0);
    chk("clrhit.count1", int'(cb[1]), 'h000);
    do_step(1'b1, 1'b1, 1'b0, "clrhold");
    chk("clrhold.count0", int'(cb[0]), 'h000);
    do_step(1'b1, 1'b0, 1'b0, "clrhold");

    // Asynchronous reset between edges at 099.
    hits(99, "pre099");
    chk("p099.count0", int'(cb[0]), 'h099);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("arst.count0", int'(cb[0]), 'h000);
    chk("arst.hex0", int'(hx0[0]), 'h40);
    chk("arst.hex1", int'(hx1[0]), 'h7f);
    check_all("arst");
    #1 reset = 1'b0;
    hits(1, "afterrst");
    chk("afterrst.count0", int'(cb[0]), 'h001);

    // Randomized traffic against the model.
    for (int r = 0; r < 3000; r++) begin
      do_step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 63) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
